// File: rtl/packet_packer_if.sv
// Handshake bundle between a narrow word stream and the packed multi-word group output.
// Master drives the word stream and consumes groups; slave is the packer.
interface packet_packer_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned WRITE_SIZE = 2
);
  localparam int unsigned CNT_W = $clog2(WRITE_SIZE + 1);

  logic [DATA_WIDTH-1:0]                  in_data;
  logic                                   in_valid;
  logic                                   in_ready;
  logic                                   flush;
  logic [0:WRITE_SIZE-1][DATA_WIDTH-1:0]  out_data;
  logic [CNT_W-1:0]                       out_count;
  logic                                   out_valid;
  logic                                   out_ready;

  modport master (
    output in_data, in_valid, flush, out_ready,
    input  in_ready, out_data, out_count, out_valid
  );

  modport slave (
    input  in_data, in_valid, flush, out_ready,
    output in_ready, out_data, out_count, out_valid
  );
endinterface

// File: rtl/packet_packer.sv
// Packs single words into WRITE_SIZE-word groups behind a registered output stage.
// A flush emits the partial group zero-padded with its true word count.
module packet_packer #(
  parameter int unsigned WRITE_SIZE = 2,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  packet_packer_if.slave   bus
);
  localparam int unsigned CNT_W = $clog2(WRITE_SIZE + 1);
  // Keep the collect array non-empty so WRITE_SIZE=1 still elaborates.
  localparam int unsigned COLL_N = (WRITE_SIZE > 1) ? WRITE_SIZE - 1 : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WRITE_SIZE - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WRITE_SIZE);

  logic [DATA_WIDTH-1:0]                 collect_q [COLL_N];
  logic [DATA_WIDTH-1:0]                 collect_d [COLL_N];
  logic [CNT_W-1:0]                      fill_cnt_q, fill_cnt_d;
  logic [0:WRITE_SIZE-1][DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0]                      out_count_q, out_count_d;
  logic                                  out_valid_q, out_valid_d;
  logic                                  flush_pending_q, flush_pending_d;

  logic out_free;
  logic in_ready;
  logic accept;
  logic completing;
  logic flush_xfer;

  assign out_free   = !out_valid_q || bus.out_ready;
  assign in_ready   = !flush_pending_q && ((fill_cnt_q != LAST_IDX) || out_free);
  assign accept     = bus.in_valid && in_ready;
  assign completing = accept && (fill_cnt_q == LAST_IDX);
  assign flush_xfer = flush_pending_q && out_free;

  assign bus.in_ready  = in_ready;
  assign bus.out_data  = out_data_q;
  assign bus.out_count = out_count_q;
  assign bus.out_valid = out_valid_q;

  always_comb begin
    collect_d       = collect_q;
    fill_cnt_d      = fill_cnt_q;
    out_data_d      = out_data_q;
    out_count_d     = out_count_q;
    out_valid_d     = out_valid_q;
    flush_pending_d = flush_pending_q;

    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    // Accepts are blocked while a flush is pending, so these branches never overlap.
    if (flush_xfer) begin
      out_data_d = '0;
      for (int i = 0; i < int'(WRITE_SIZE) - 1; i++) begin
        if (CNT_W'(i) < fill_cnt_q) begin
          out_data_d[i] = collect_q[i];
        end
      end
      out_count_d     = fill_cnt_q;
      out_valid_d     = 1'b1;
      fill_cnt_d      = '0;
      flush_pending_d = 1'b0;
    end else if (completing) begin
      for (int i = 0; i < int'(WRITE_SIZE) - 1; i++) begin
        out_data_d[i] = collect_q[i];
      end
      out_data_d[WRITE_SIZE-1] = bus.in_data;
      out_count_d = FULL_CNT;
      out_valid_d = 1'b1;
      fill_cnt_d  = '0;
    end else if (accept) begin
      for (int i = 0; i < int'(COLL_N); i++) begin
        if (CNT_W'(i) == fill_cnt_q) begin
          collect_d[i] = bus.in_data;
        end
      end
      fill_cnt_d = fill_cnt_q + CNT_W'(1);
    end

    // Judged on the post-accept fill so a word arriving with flush joins the flushed group.
    if (bus.flush && !flush_pending_q && (fill_cnt_d != '0)) begin
      flush_pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      collect_q       <= '{default: '0};
      fill_cnt_q      <= '0;
      out_data_q      <= '0;
      out_count_q     <= '0;
      out_valid_q     <= 1'b0;
      flush_pending_q <= 1'b0;
    end else begin
      collect_q       <= collect_d;
      fill_cnt_q      <= fill_cnt_d;
      out_data_q      <= out_data_d;
      out_count_q     <= out_count_d;
      out_valid_q     <= out_valid_d;
      flush_pending_q <= flush_pending_d;
    end
  end

endmodule

// File: tb/tb_packet_packer.sv
// Randomised and directed checks of packet_packer (WRITE_SIZE=2 and WRITE_SIZE=1 builds)
// against a queue-based reference model of the word stream and output group slot.
module tb_packet_packer;
  localparam int DW = 8;
  localparam int WS = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  packet_packer_if #(.DATA_WIDTH(DW), .WRITE_SIZE(WS)) bus ();
  packet_packer_if #(.DATA_WIDTH(DW), .WRITE_SIZE(1))  bus1 ();

  packet_packer #(.WRITE_SIZE(WS), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  packet_packer #(.WRITE_SIZE(1), .DATA_WIDTH(DW)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model for WS=2: words collected so far, the held output group, pending flush.
  logic [7:0] part[$];
  logic [7:0] held[WS];
  int         held_cnt;
  bit         held_v;
  bit         pend;

  // Reference model for the WS=1 build: only the held output word matters.
  logic [7:0] held1;
  bit         held1_v;

  task automatic model_clear();
    part.delete();
    for (int i = 0; i < WS; i++) held[i] = '0;
    held_cnt = 0;
    held_v   = 0;
    pend     = 0;
    held1    = '0;
    held1_v  = 0;
  endtask

  task automatic step(input bit v, input logic [7:0] d, input bit fl, input bit rdy);
    bit exp_ready, acc, free;
    logic [0:WS-1][7:0] exp_data;
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.flush     = fl;
    bus.out_ready = rdy;
    #1;
    free      = !held_v || rdy;
    exp_ready = !pend && ((part.size() < WS - 1) || free);
    for (int i = 0; i < WS; i++) exp_data[i] = held[i];
    check_eq("in_ready", bus.in_ready, exp_ready);
    check_eq("out_valid", bus.out_valid, held_v);
    if (held_v) begin
      check_eq("out_count", bus.out_count, held_cnt);
      check_eq("out_data", bus.out_data, exp_data);
    end
    acc = v && exp_ready;
    @(posedge clk);
    #1;
    if (held_v && rdy) held_v = 0;
    if (pend) begin
      if (free) begin
        for (int i = 0; i < WS; i++) held[i] = (i < part.size()) ? part[i] : 8'h00;
        held_cnt = part.size();
        held_v   = 1;
        part.delete();
        pend     = 0;
      end
    end else begin
      if (acc) begin
        part.push_back(d);
        if (part.size() == WS) begin
          for (int i = 0; i < WS; i++) held[i] = part[i];
          held_cnt = WS;
          held_v   = 1;
          part.delete();
        end
      end
      if (fl && part.size() > 0) pend = 1;
    end
  endtask

  task automatic step1(input bit v, input logic [7:0] d, input bit fl, input bit rdy);
    bit exp_ready;
    @(negedge clk);
    bus1.in_valid  = v;
    bus1.in_data   = d;
    bus1.flush     = fl;
    bus1.out_ready = rdy;
    #1;
    exp_ready = !held1_v || rdy;
    check_eq("ws1_in_ready", bus1.in_ready, exp_ready);
    check_eq("ws1_out_valid", bus1.out_valid, held1_v);
    if (held1_v) begin
      check_eq("ws1_out_count", bus1.out_count, 1);
      check_eq("ws1_out_data", bus1.out_data, held1);
    end
    @(posedge clk);
    #1;
    if (held1_v && rdy) held1_v = 0;
    if (v && exp_ready) begin
      held1   = d;
      held1_v = 1;
    end
  endtask

  task automatic idle_inputs();
    bus.in_valid   = 0; bus.in_data  = '0; bus.flush  = 0; bus.out_ready  = 0;
    bus1.in_valid  = 0; bus1.in_data = '0; bus1.flush = 0; bus1.out_ready = 0;
  endtask

  // Reset dropped between clock edges: outputs must clear without waiting for clk.
  task automatic mid_reset();
    @(negedge clk);
    bus.in_valid = 1;
    bus.in_data  = 8'h99;
    #2;
    rst = 0;
    #1;
    check_eq("rst_out_valid", bus.out_valid, 0);
    check_eq("rst_out_count", bus.out_count, 0);
    check_eq("rst_out_data", bus.out_data, 0);
    check_eq("rst_in_ready", bus.in_ready, 1);
    check_eq("rst_ws1_out_valid", bus1.out_valid, 0);
    idle_inputs();
    model_clear();
    @(negedge clk);
    rst = 1;
  endtask

  initial begin
    idle_inputs();
    model_clear();
    rst = 0;
    #3;
    check_eq("init_out_valid", bus.out_valid, 0);
    check_eq("init_out_count", bus.out_count, 0);
    check_eq("init_in_ready", bus.in_ready, 1);
    @(negedge clk);
    rst = 1;

    // Streaming at full rate.
    step(1, 8'h11, 0, 1); step(1, 8'h22, 0, 1); step(1, 8'h33, 0, 1); step(1, 8'h44, 0, 1);
    step(0, 8'h00, 0, 1); step(0, 8'h00, 0, 1);

    // Backpressure: fourth word stalls until the held group drains.
    step(1, 8'h01, 0, 0); step(1, 8'h02, 0, 0); step(1, 8'h03, 0, 0); step(1, 8'h04, 0, 0);
    step(1, 8'h04, 0, 1); step(0, 8'h00, 0, 0); step(0, 8'h00, 0, 1); step(0, 8'h00, 0, 1);

    // Partial flush.
    step(1, 8'h55, 0, 1); step(0, 8'h00, 1, 1); step(1, 8'h66, 0, 1); step(0, 8'h00, 0, 1);
    step(1, 8'h67, 1, 1); step(0, 8'h00, 0, 1); step(0, 8'h00, 0, 1);

    // Flush together with a completing word, then flush with nothing collected.
    step(1, 8'hAA, 0, 1); step(1, 8'hBB, 1, 1); step(0, 8'h00, 0, 1); step(0, 8'h00, 1, 1);
    step(0, 8'h00, 0, 1);

    // Flush while stalled; a second flush while pending is ignored.
    step(1, 8'hC1, 0, 0); step(1, 8'hC2, 0, 0); step(1, 8'hC3, 0, 0); step(0, 8'h00, 1, 0);
    step(1, 8'hC4, 1, 0); step(1, 8'hC4, 0, 1); step(1, 8'hC4, 0, 0); step(0, 8'h00, 0, 1);
    step(0, 8'h00, 0, 1);

    // Reset mid-stream with a partial group and a pending flush outstanding.
    step(1, 8'h77, 0, 0); step(1, 8'h78, 0, 0); step(1, 8'h79, 1, 0);
    mid_reset();
    step(0, 8'h00, 0, 1); step(1, 8'h12, 0, 1); step(1, 8'h34, 0, 1); step(0, 8'h00, 0, 1);

    // Randomised traffic on the WS=2 build.
    for (int n = 0; n < 3000; n++) begin
      step(($urandom % 4) != 0, 8'($urandom), ($urandom % 6) == 0, ($urandom % 3) != 0);
    end
    step(0, 8'h00, 1, 1); step(0, 8'h00, 0, 1); step(0, 8'h00, 0, 1);

    // WS=1 build: every accepted word emits alone, flush has nothing to add.
    step1(1, 8'h5A, 0, 1); step1(1, 8'hA5, 0, 0); step1(1, 8'h3C, 1, 0);
    step1(1, 8'h3C, 0, 1); step1(0, 8'h00, 1, 1); step1(0, 8'h00, 0, 1);
    for (int n = 0; n < 300; n++) begin
      step1(($urandom % 4) != 0, 8'($urandom), ($urandom % 5) == 0, ($urandom % 3) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/packet_packer.md
# packet_packer

Upstream feeder for the instant buffer. It accepts a narrow stream of single `DATA_WIDTH` words over a valid/ready handshake and packs them into groups of `WRITE_SIZE` words. Each group is presented on a registered output with its own valid/ready handshake, matching the buffer's multi-word write port. A flush request emits a trailing partial group, zero-padded, with its true word count.

## Interface
- `WRITE_SIZE`, 2: words per output group; must be ≥1.
- `DATA_WIDTH`, 8: bits per word.
- `CNT_W` (localparam) = `$clog2(WRITE_SIZE+1)`.

- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `in_data`  in  `DATA_WIDTH`  incoming word.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  block accepts `in_data` this cycle; combinational.
- `flush`  in  1  single-cycle pulse requesting emission of the partial group.
- `out_data`  out  `[DATA_WIDTH-1:0] [0:WRITE_SIZE-1]`  packed group; index 0 holds the oldest word.
- `out_count`  out  `CNT_W`  number of valid words in `out_data` (1..`WRITE_SIZE`).
- `out_valid`  out  1  output group held and valid.
- `out_ready`  in  1  downstream consumes the group this cycle.

## Operation
- **State**
  - collect array of `WRITE_SIZE`-1 words.
  - `fill_cnt`, range 0..`WRITE_SIZE`-1.
  - output register: `out_data`, `out_count`, `out_valid`.
  - `flush_pending` flag.
- **Reset values:** `fill_cnt`=0, collect array=0, `out_data`=0, `out_count`=0, `out_valid`=0, `flush_pending`=0.
- **Derived signals:**
  - `out_free` = !`out_valid` | `out_ready`.
  - accept = `in_valid` & `in_ready`.
  - `in_ready` = !`flush_pending` & ((`fill_cnt` != `WRITE_SIZE`-1) | `out_free`).
- **Accept, non-completing** (`fill_cnt` < `WRITE_SIZE`-1): `in_data` is written to collect[`fill_cnt`]; `fill_cnt`++.
- **Accept, completing** (`fill_cnt` == `WRITE_SIZE`-1):
  - output register loads {collect[0..WRITE_SIZE-2], `in_data`}.
  - `out_count`=`WRITE_SIZE`, `out_valid`=1, `fill_cnt`=0.
  - With `WRITE_SIZE`=1, every accept is completing.
- **Flush:**
  - `flush` sets `flush_pending` only if, after this cycle's accept, `fill_cnt` > 0.
  - A word accepted in the same cycle as `flush` is included in the flushed group.
  - If that word completes a group, the full group is emitted and no flush is pending.
- **Flush transfer:** while `flush_pending`=1 and `out_free`:
  - output register loads collect[0..`fill_cnt`-1], with zeros in the remaining slots.
  - `out_count`=`fill_cnt`, `out_valid`=1.
  - `fill_cnt`=0, `flush_pending`=0.
  - `in_ready`=0 for the whole time `flush_pending`=1.
- **Output release:** on `out_valid` & `out_ready`, `out_valid` clears unless a new group loads on the same edge. A load in that cycle overwrites the register with no bubble.
- `flush` while `fill_cnt`=0 and no accept is ignored.
- `flush` while `flush_pending`=1 is ignored.
- `out_data`/`out_count` hold their value while `out_valid`=1 and `out_ready`=0.

## Timing
- **Latency:** the group appears on the outputs the cycle after the edge that accepted its last word or executed the flush transfer. That is one cycle, combinational-free at the output.
- **Throughput:** one word per cycle sustained while `out_ready`=1. One group every `WRITE_SIZE` cycles.
- **Backpressure:** capacity is one full group in the output register plus `WRITE_SIZE`-1 collected words. Once both are occupied and `out_ready`=0, `in_ready` drops. It rises combinationally in the cycle `out_ready` goes high.
- **Asynchronous reset:** `rst` low clears all state immediately, regardless of `clk`. A partial group or pending flush is discarded.
  - `in_ready` returns to 1 while `rst` is low.
  - `out_valid`=0 until a new group completes after reset release.

## Test plan
- **Reset:** assert `rst`=0 mid-stream without a clock edge → `out_valid`=0, `out_count`=0, `out_data`={0,0} and `in_ready`=1 immediately.
- **Streaming:** `WRITE_SIZE`=2, `out_ready`=1, stream 0x11,0x22,0x33,0x44 on consecutive cycles → group {0x11,0x22}, count 2, one cycle after accepting 0x22. Then {0x33,0x44}, count 2, two cycles later; `in_ready` stays 1 throughout.
- **Backpressure:** `out_ready`=0, offer 0x01..0x04 → 0x01,0x02,0x03 accepted; `in_ready`=0 with 0x04 held.
  - Raise `out_ready` for 1 cycle → {0x01,0x02} consumed and 0x04 accepted that same cycle.
  - Next cycle out = {0x03,0x04}.
- **Partial flush:** accept 0x55, pulse `flush` next cycle → out {0x55,0x00}, count 1, the following cycle. `in_ready`=0 only during the pending cycle.
- **Flush with simultaneous word:** `fill_cnt`=1 holding 0xAA; `flush` together with accepted 0xBB → out {0xAA,0xBB}, count 2. No extra partial group; `flush_pending` stays 0.
- **Flush while stalled:** flush with a partial group while `out_valid`=1 and `out_ready`=0 → `flush_pending`=1, `in_ready`=0.
  - Partial group loads on the edge where the old group is consumed.
  - `WRITE_SIZE`=1 build: every accepted word emits immediately with count 1.
